// File: rtl/lisp_core.sv
// Lisp machine evaluator core: latches a tagged word from the switches,
// evaluates it against the heap, and shows the result on the display and LEDs.

module lisp_heap #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);
   logic [15:0] memory [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we)
         memory[addr] <= wdata;
      if (re)
         rdata <= memory[addr];
   end
endmodule

module lisp_core #(
   parameter int MEM_DEPTH    = 256,
   parameter int REFRESH_BITS = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic [15:0] switches,
   output logic [7:0]  cathodes,
   output logic [3:0]  anodes,
   output logic [15:0] leds
);
   localparam logic [2:0] TYPE_NUMBER = 3'b000;
   localparam logic [2:0] TYPE_CONS   = 3'b001;

   typedef enum logic [2:0] {
      Idle     = 3'd0,
      Load     = 3'd1,
      Eval     = 3'd2,
      ReadWait = 3'd3,
      Halt     = 3'd4,
      Error    = 3'd5
   } state_t;

   state_t state, state_next;

   logic [15:0] val;
   logic [3:0]  error;
   logic [15:0] expr;
   logic        btn_q, btn_q_prev;
   logic        start_pulse;
   logic [REFRESH_BITS-1:0] scan_cnt;
   logic [15:0] leds_hold;
   logic [15:0] heap_rdata;
   logic        heap_re;
   logic [1:0]  digit;
   logic [3:0]  nibble;
   logic [6:0]  seg;

   wire [2:0] expr_type = expr[14:12];
   wire       ptr_oob   = (expr[11:8] != 4'h0);

   lisp_heap #(.DEPTH(MEM_DEPTH), .AW(8)) mem (
      .clk   (clk),
      .we    (1'b0),
      .re    (heap_re),
      .addr  (expr[7:0]),
      .wdata (16'h0000),
      .rdata (heap_rdata)
   );

   assign start_pulse = btn_q & ~btn_q_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= Idle;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         Idle:     if (start_pulse) state_next = Load;
         Load:     state_next = Eval;
         // Out-of-range pointer wins over the type decode.
         Eval: begin
            if (ptr_oob)
               state_next = Error;
            else if (expr_type == TYPE_NUMBER)
               state_next = ReadWait;
            else if (expr_type == TYPE_CONS)
               state_next = Halt;
            else
               state_next = Error;
         end
         ReadWait: state_next = Halt;
         Halt,
         Error:    if (start_pulse) state_next = Load;
         default:  state_next = Idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q      <= 1'b0;
         btn_q_prev <= 1'b0;
         val        <= 16'h0000;
         error      <= 4'h0;
         expr       <= 16'h0000;
         scan_cnt   <= '0;
         leds_hold  <= 16'h0000;
      end else begin
         btn_q      <= btn_start;
         btn_q_prev <= btn_q;
         scan_cnt   <= scan_cnt + 1'b1;
         leds_hold  <= leds;
         case (state)
            Load: begin
               expr  <= switches;
               error <= 4'h0;
            end
            Eval: begin
               if (ptr_oob)
                  error <= 4'h2;
               else if (expr_type == TYPE_CONS)
                  val <= expr;
               else if (expr_type != TYPE_NUMBER)
                  error <= 4'h1;
            end
            ReadWait: val <= heap_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      heap_re = (state == Eval) && !ptr_oob && (expr_type == TYPE_NUMBER);

      case (state)
         Halt:    leds = val;
         Error:   leds = {12'h000, error};
         Idle:    leds = 16'h0000;
         default: leds = leds_hold;
      endcase

      digit     = scan_cnt[REFRESH_BITS-1 -: 2];
      anodes    = 4'b1111;
      anodes[digit] = 1'b0;

      // Error screen reads "E00" then the error code on the rightmost digit.
      if (state == Error) begin
         case (digit)
            2'd3:    nibble = 4'hE;
            2'd0:    nibble = error;
            default: nibble = 4'h0;
         endcase
      end else begin
         nibble = val[digit*4 +: 4];
      end

      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      cathodes = {1'b1, seg};
   end
endmodule

// File: tb/tb_lisp_core.sv
// Randomised self-checking bench for lisp_core against a word-level evaluation model.

module tb_lisp_core;
   localparam int RB = 8;
   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_READWAIT = 3'd3,
                          S_HALT = 3'd4, S_ERROR = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        btn_start = 1'b0;
   logic [15:0] switches = 16'h0000;
   logic [7:0]  cathodes;
   logic [3:0]  anodes;
   logic [15:0] leds;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] model_mem [0:255];
   logic [15:0] mval = 16'h0000;
   logic [3:0]  merr = 4'h0;
   logic [7:0]  glyph [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   lisp_core #(.MEM_DEPTH(256), .REFRESH_BITS(RB)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .switches  (switches),
      .cathodes  (cathodes),
      .anodes    (anodes),
      .leds      (leds)
   );

   always #5 clk = ~clk;

   task automatic heap_write(input int a, input logic [15:0] d);
      model_mem[a] = d;
      dut.mem.memory[a] = d;
   endtask

   // Evaluation rules: out-of-range first, then number -> heap, cons -> itself, else bad type.
   task automatic model_eval(input logic [15:0] w, output int lat);
      if (w[11:8] != 4'h0) begin
         merr = 4'h2; lat = 3;
      end else if (w[14:12] == 3'd0) begin
         mval = model_mem[w[7:0]]; merr = 4'h0; lat = 4;
      end else if (w[14:12] == 3'd1) begin
         mval = w; merr = 4'h0; lat = 3;
      end else begin
         merr = 4'h1; lat = 3;
      end
   endtask

   // Pulses start for one cycle and returns the edges from the registered press to a final state.
   task automatic run_eval(input logic [15:0] w, output int lat);
      switches = w;
      @(negedge clk) btn_start = 1'b1;
      @(negedge clk) btn_start = 1'b0;
      lat = 99;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (dut.state == S_HALT || dut.state == S_ERROR) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic wait_digit(input int d, output bit ok);
      logic [3:0] an_exp;
      an_exp = ~(4'b0001 << d);
      ok = 1'b0;
      for (int i = 0; i < (8 << RB); i++) begin
         @(negedge clk);
         if (anodes == an_exp) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [7:0] exp_cath(input int d, input bit in_err);
      logic [3:0] nib;
      if (in_err)
         nib = (d == 3) ? 4'hE : (d == 0) ? merr : 4'h0;
      else
         nib = mval[d*4 +: 4];
      return glyph[nib];
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (dut.state !== S_IDLE || dut.val !== 16'h0 || dut.error !== 4'h0 || leds !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_regs: state=%0d val=%h error=%h leds=%h required 0/0000/0/0000",
                  dut.state, dut.val, dut.error, leds);
      end
      n_checks++;
      if (anodes !== 4'b1110 || cathodes !== 8'hC0) begin
         n_fail++;
         $display("FAIL reset_display: anodes=%b cathodes=%h required 1110/c0", anodes, cathodes);
      end
      @(negedge clk) rst = 1'b1;
      $display("reset: state=%0d anodes=%b cathodes=%h", dut.state, anodes, cathodes);
   endtask

   task automatic test_number();
      int lat, exp_lat;
      bit ok;
      heap_write(1, 16'hDEAD);
      run_eval(16'h0001, lat);
      model_eval(16'h0001, exp_lat);
      n_checks++;
      if (lat !== exp_lat || dut.state !== S_HALT) begin
         n_fail++;
         $display("FAIL number_latency: lat=%0d state=%0d required %0d/%0d", lat, dut.state, exp_lat, S_HALT);
      end
      n_checks++;
      if (dut.val !== mval || leds !== mval || dut.error !== 4'h0) begin
         n_fail++;
         $display("FAIL number_val: val=%h leds=%h error=%h required %h/%h/0", dut.val, leds, dut.error, mval, mval);
      end
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, ok);
         n_checks++;
         if (!ok || cathodes !== exp_cath(d, 1'b0)) begin
            n_fail++;
            $display("FAIL number_digit%0d: found=%0d cathodes=%h required %h", d, ok, cathodes, exp_cath(d, 1'b0));
         end
      end
      $display("number: sw=0001 val=%h leds=%h lat=%0d", dut.val, leds, lat);
   endtask

   task automatic test_cons();
      int lat, exp_lat;
      heap_write(1, 16'hBEEF); heap_write(2, 16'hDEAD);
      heap_write(3, 16'h0001); heap_write(4, 16'h0002);
      run_eval(16'h1004, lat);
      model_eval(16'h1004, exp_lat);
      n_checks++;
      if (lat !== exp_lat || dut.state !== S_HALT || dut.val !== 16'h1004 || leds !== 16'h1004) begin
         n_fail++;
         $display("FAIL cons_eval: lat=%0d state=%0d val=%h leds=%h required %0d/%0d/1004/1004",
                  lat, dut.state, dut.val, leds, exp_lat, S_HALT);
      end
      $display("cons: sw=1004 val=%h lat=%0d", dut.val, lat);
   endtask

   task automatic test_bad_type();
      int lat, exp_lat;
      bit ok;
      run_eval(16'h3005, lat);
      model_eval(16'h3005, exp_lat);
      n_checks++;
      if (lat !== exp_lat || dut.state !== S_ERROR || dut.error !== 4'h1 || leds !== 16'h0001) begin
         n_fail++;
         $display("FAIL bad_type: lat=%0d state=%0d error=%h leds=%h required %0d/%0d/1/0001",
                  lat, dut.state, dut.error, leds, exp_lat, S_ERROR);
      end
      n_checks++;
      if (dut.val !== mval) begin
         n_fail++;
         $display("FAIL bad_type_val_hold: val=%h required %h", dut.val, mval);
      end
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, ok);
         n_checks++;
         if (!ok || cathodes !== exp_cath(d, 1'b1)) begin
            n_fail++;
            $display("FAIL err_digit%0d: found=%0d cathodes=%h required %h", d, ok, cathodes, exp_cath(d, 1'b1));
         end
      end
      $display("bad_type: sw=3005 error=%h leds=%h", dut.error, leds);
   endtask

   task automatic test_out_of_range();
      int lat, exp_lat;
      run_eval(16'h0100, lat);
      model_eval(16'h0100, exp_lat);
      n_checks++;
      if (lat !== exp_lat || dut.state !== S_ERROR || dut.error !== 4'h2 || leds !== 16'h0002) begin
         n_fail++;
         $display("FAIL out_of_range: lat=%0d state=%0d error=%h leds=%h required %0d/%0d/2/0002",
                  lat, dut.state, dut.error, leds, exp_lat, S_ERROR);
      end
      $display("out_of_range: sw=0100 error=%h", dut.error);
   endtask

   task automatic test_rerun_hold();
      int lat, loads;
      heap_write(7, 16'h1234);
      switches = 16'h0007;
      model_eval(16'h0007, lat);
      loads = 0;
      @(negedge clk) btn_start = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (dut.state == S_LOAD) loads++;
      end
      btn_start = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (dut.state == S_LOAD) loads++;
      end
      n_checks++;
      if (loads !== 1 || dut.state !== S_HALT || dut.val !== mval || leds !== mval) begin
         n_fail++;
         $display("FAIL rerun_hold: loads=%0d state=%0d val=%h leds=%h required 1/%0d/%h/%h",
                  loads, dut.state, dut.val, leds, S_HALT, mval, mval);
      end
      $display("rerun_hold: sw=0007 loads=%0d val=%h", loads, dut.val);
   endtask

   task automatic test_random();
      int lat, exp_lat, r;
      logic [15:0] w;
      for (int i = 0; i < 32; i++)
         heap_write($urandom_range(0, 255), 16'($urandom));
      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 9);
         w = 16'($urandom);
         w[11:8] = 4'h0;
         if (r <= 4)      w[14:12] = 3'd0;
         else if (r <= 7) w[14:12] = 3'd1;
         else if (r == 8) w[14:12] = 3'($urandom_range(2, 7));
         else             w[11:8]  = 4'($urandom_range(1, 15));
         run_eval(w, lat);
         model_eval(w, exp_lat);
         n_checks++;
         if (lat !== exp_lat || dut.val !== mval || dut.error !== merr ||
             dut.state !== ((merr != 4'h0) ? S_ERROR : S_HALT) ||
             leds !== ((merr != 4'h0) ? {12'h000, merr} : mval)) begin
            n_fail++;
            $display("FAIL random_%0d: sw=%h lat=%0d val=%h error=%h leds=%h required %0d/%h/%h",
                     n, w, lat, dut.val, dut.error, leds, exp_lat, mval, merr);
         end
         $display("random %0d: sw=%h val=%h error=%h leds=%h", n, w, dut.val, dut.error, leds);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      logic [3:0] seen_mask;
      bit onehot_ok;
      heap_write(9, 16'hA5C3);
      switches = 16'h0009;
      @(negedge clk) btn_start = 1'b1;
      @(negedge clk) btn_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dut.state == S_READWAIT) begin
            seen = 1'b1;
            break;
         end
      end
      rst = 1'b0;
      #1;
      mval = 16'h0000; merr = 4'h0;
      n_checks++;
      if (!seen || dut.state !== S_IDLE || dut.val !== 16'h0 || anodes !== 4'b1110 || leds !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid: seen=%0d state=%0d val=%h anodes=%b leds=%h required 1/%0d/0000/1110/0000",
                  seen, dut.state, dut.val, anodes, leds, S_IDLE);
      end
      n_checks++;
      if (dut.mem.memory[9] !== model_mem[9] || dut.mem.memory[7] !== model_mem[7] ||
          dut.mem.memory[1] !== model_mem[1]) begin
         n_fail++;
         $display("FAIL heap_kept: m9=%h m7=%h m1=%h required %h/%h/%h", dut.mem.memory[9],
                  dut.mem.memory[7], dut.mem.memory[1], model_mem[9], model_mem[7], model_mem[1]);
      end
      @(negedge clk) rst = 1'b1;
      seen_mask = 4'h0;
      onehot_ok = 1'b1;
      for (int i = 0; i < (1 << RB); i++) begin
         @(negedge clk);
         if ($countones(~anodes) != 1) onehot_ok = 1'b0;
         seen_mask = seen_mask | ~anodes;
      end
      n_checks++;
      if (!onehot_ok || seen_mask !== 4'hF) begin
         n_fail++;
         $display("FAIL scan: onehot=%0d seen=%b required 1/1111", onehot_ok, seen_mask);
      end
      $display("reset_mid: state=%0d val=%h scan_seen=%b", dut.state, dut.val, seen_mask);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) heap_write(i, 16'h0000);
      test_reset();
      test_number();
      test_cons();
      test_bad_type();
      test_out_of_range();
      test_rerun_hold();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/lisp_core.md
Name: lisp_core

Overview:
- Top-level evaluator core of the Lisp machine.
- Accepts a 16-bit tagged expression word from the board switches when the start button is pressed.
- Evaluates the word against an internal 256x16 tagged heap memory, then halts with the result in val.
- Shows the result on the 4-digit seven-segment display and the LEDs.

Parameters:
- MEM_DEPTH, 256, heap words; address = low 8 bits of the 12-bit pointer field.
- REFRESH_BITS, 17, width of the display scan counter; top 2 bits select the digit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all registers except heap contents.
- btn_start  in  1  start button, synchronous to clk, level; a rising edge starts evaluation.
- switches  in  16  expression word to evaluate.
- cathodes  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1 (off).
- anodes  out  4  active-low digit enables; anodes[0] is the rightmost digit.
- leds  out  16  result or error display.

Behaviour:
- Word format: [15] reserved (ignored); [14:12] type; [11:0] pointer.
- Type codes: TYPE_NUMBER=3'b000, TYPE_CONS=3'b001; 010–111 are undefined.
- Internal observable names, probed by verification, must exist exactly:
  - state register with enumerated states Idle, Load, Eval, ReadWait, Halt, Error.
  - 16-bit register val.
  - 4-bit register error.
  - heap instance mem containing array memory[0:MEM_DEPTH-1] of 16-bit words.
  - localparams TYPE_NUMBER and TYPE_CONS.
- Heap:
  - single-port RAM, synchronous read, 1-cycle latency.
  - never cleared by reset; initialised to zero at time 0.
  - write port present but unused (tied off).
- Cons cell at address A: car = memory[A], cdr = memory[A-1] (8-bit wrap).
- Start detection:
  - btn_start is registered once; start_pulse = btn_q & ~btn_q_prev.
  - A single-cycle high on btn_start must be detected.
  - Holding the button produces exactly one start.
- Reset values:
  - state=Idle, val=0, error=0, expr=0, scan counter=0.
  - leds=0, anodes=4'b1110, cathodes showing digit 0 of val (0).
- Transitions:
  - Idle: on start_pulse, go to Load.
  - Load: expr <= switches; error <= 0; go to Eval.
  - Eval, type NUMBER: drive mem address = expr[7:0]; go to ReadWait.
  - Eval, type CONS: val <= expr (cons is self-evaluating; returns the pointer word); go to Halt.
  - Eval, other type: error <= 4'h1; go to Error.
  - Eval, pointer[11:8] != 0 (address >= MEM_DEPTH): error <= 4'h2; go to Error. This check has priority over the type decode.
  - ReadWait: val <= mem read data; go to Halt.
  - Halt / Error: hold val and error; on start_pulse go to Load (re-evaluate the current switches).
- Latency:
  - NUMBER: 4 cycles after the edge registered in btn_q.
  - CONS: 3 cycles.
- A start_pulse arriving in Load, Eval or ReadWait is ignored.
- Reset asserted mid-evaluation returns to Idle immediately; heap is unchanged.
- Display:
  - Free-running scan counter.
  - Digit k (k=0..3) shows hex nibble val[4k+3:4k] when not in Error.
  - In Error, shows "E00" followed by the error nibble.
  - One anode low at a time.
  - Hex glyphs 0–F use standard active-low encoding (0 → 8'hC0).
- leds:
  - val in Halt.
  - {12'h000, error} in Error.
  - 16'h0000 in Idle.
  - previous value held otherwise.

Test Plan:
- Number eval: memory[1]=16'hDEAD, switches=16'h0001, pulse btn_start one cycle -> state Halt, val=16'hDEAD, leds=16'hDEAD, error=0.
- Cons eval: memory[1]=BEEF, [2]=DEAD, [3]=0001, [4]=0002, switches=16'h1004, pulse -> Halt, val=16'h1004, no heap read.
- Bad type: switches=16'h3005, pulse -> state Error, error=4'h1, leds=16'h0001, display "E001".
- Out-of-range pointer: switches=16'h0100, pulse -> Error, error=4'h2.
- Re-run from Halt: after the number test, set memory[7]=16'h1234 and switches=16'h0007, pulse -> val=16'h1234; holding btn_start high 10 cycles yields exactly one evaluation.
- Reset mid-run: assert rst low during ReadWait -> state Idle, val=0, anodes=4'b1110; heap contents preserved; scan through all 4 anodes in 2^REFRESH_BITS cycles.
